vga_pmod_timing: RTL

Parametrised VGA timing generator and TinyVGA PMOD output stage, the successor to the fixed-mode sync logic inside the current graphics path. It generates the pixel/line counters and coordinates a renderer consumes. It delays sync and blanking by a configurable renderer latency so they line up with the returned colour. It packs the result onto the 8-bit `uo_out` PMOD bus, with optional 2×2 ordered dithering from 4-bit to 2-bit colour channels.

---
 rtl/vga_pmod_timing.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/vga_pmod_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_pmod_timing
// Brief    : VGA timing counters, latency-matched sync and TinyVGA PMOD packing
// Revision : 1.0
// ============================================================================
module vga_pmod_timing #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FRONT    = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BACK     = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FRONT    = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BACK     = 33,
    parameter logic H_POL      = 1'b0,
    parameter logic V_POL      = 1'b0,
    parameter int   PIPE_DELAY = 2,
    parameter int   COLOR_BITS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    output logic [9:0]                x,
    output logic [9:0]                y,
    output logic                      active,
    output logic                      line_start,
    output logic                      frame_start,
    input  logic [3*COLOR_BITS-1:0]   rgb_in,
    output logic [7:0]                vga_pmod
);

    localparam int          c_H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int          c_V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0]  c_H_LAST  = 10'(c_H_TOTAL - 1);
    localparam logic [9:0]  c_V_LAST  = 10'(c_V_TOTAL - 1);
    localparam logic [10:0] c_H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] c_HS_BEG  = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] c_HS_END  = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] c_V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] c_VS_BEG  = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] c_VS_END  = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic [10:0] w_x_ext;
    logic [10:0] w_y_ext;
    logic        w_active;
    logic        w_hs_raw;
    logic        w_vs_raw;
    logic [4:0]  w_tap;
    logic [4:0]  w_dly;
    logic        w_d_active;
    logic        w_d_hs;
    logic        w_d_vs;
    logic        w_d_x0;
    logic        w_d_y0;
    logic [1:0]  w_r;
    logic [1:0]  w_g;
    logic [1:0]  w_b;
    logic [1:0]  w_r_m;
    logic [1:0]  w_g_m;
    logic [1:0]  w_b_m;
    logic        w_hsync;
    logic        w_vsync;
    logic [7:0]  r_pmod;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (en) begin
            if (r_x == c_H_LAST) begin
                r_x <= '0;
                r_y <= (r_y == c_V_LAST) ? 10'd0 : r_y + 10'd1;
            end else begin
                r_x <= r_x + 10'd1;
            end
        end
    end

    assign w_x_ext  = {1'b0, r_x};
    assign w_y_ext  = {1'b0, r_y};
    assign w_active = (w_x_ext < c_H_ACT) && (w_y_ext < c_V_ACT);
    assign w_hs_raw = (w_x_ext >= c_HS_BEG) && (w_x_ext < c_HS_END);
    assign w_vs_raw = (w_y_ext >= c_VS_BEG) && (w_y_ext < c_VS_END);

    assign x           = r_x;
    assign y           = r_y;
    assign active      = w_active;
    assign line_start  = (r_x == 10'd0);
    assign frame_start = (r_x == 10'd0) && (r_y == 10'd0);

    // The pixel parity travels with sync/blank so the dither phase matches the returned colour.
    assign w_tap = {w_active, w_hs_raw, w_vs_raw, r_x[0], r_y[0]};

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign w_dly = w_tap;
        end else begin : g_delay
            logic [4:0] r_stage [PIPE_DELAY];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_DELAY; i++) r_stage[i] <= '0;
                end else if (en) begin
                    r_stage[0] <= w_tap;
                    for (int i = 1; i < PIPE_DELAY; i++) r_stage[i] <= r_stage[i-1];
                end
            end
            assign w_dly = r_stage[PIPE_DELAY-1];
        end
    endgenerate

    assign {w_d_active, w_d_hs, w_d_vs, w_d_x0, w_d_y0} = w_dly;

    function automatic logic [1:0] f_dither(input logic [3:0] c, input logic [1:0] thr);
        logic [2:0] sum;
        sum = {1'b0, c[3:2]} + {2'b00, (c[1:0] > thr)};
        return sum[2] ? 2'b11 : sum[1:0];
    endfunction

    generate
        if (COLOR_BITS == 4) begin : g_dither
            logic [1:0] w_thr;
            always_comb begin
                w_thr = 2'd1;
                case ({w_d_x0, w_d_y0})
                    2'b00:   w_thr = 2'd0;
                    2'b10:   w_thr = 2'd2;
                    2'b01:   w_thr = 2'd3;
                    default: w_thr = 2'd1;
                endcase
            end
            assign w_r = f_dither(rgb_in[8 +: 4], w_thr);
            assign w_g = f_dither(rgb_in[4 +: 4], w_thr);
            assign w_b = f_dither(rgb_in[0 +: 4], w_thr);
        end else begin : g_direct
            logic w_unused_phase;
            assign w_unused_phase = w_d_x0 ^ w_d_y0;
            assign w_r = rgb_in[4 +: 2];
            assign w_g = rgb_in[2 +: 2];
            assign w_b = rgb_in[0 +: 2];
        end
    endgenerate

    assign w_r_m   = w_r & {2{w_d_active}};
    assign w_g_m   = w_g & {2{w_d_active}};
    assign w_b_m   = w_b & {2{w_d_active}};
    assign w_hsync = w_d_hs ? H_POL : ~H_POL;
    assign w_vsync = w_d_vs ? V_POL : ~V_POL;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pmod <= {~H_POL, 3'b000, ~V_POL, 3'b000};
        end else if (en) begin
            r_pmod <= {w_hsync, w_b_m[0], w_g_m[0], w_r_m[0],
                       w_vsync, w_b_m[1], w_g_m[1], w_r_m[1]};
        end
    end

    assign vga_pmod = r_pmod;

endmodule
`default_nettype wire
